multi_cycle_sequencer: RTL
==========================

Name: multi_cycle_sequencer

Overview:
- State register and next-state logic for the multi-cycle MIPS datapath.
- Produces the 4-bit current_state that the control-signal decoder consumes; the encoding is fixed by that decoder.
- Steps each instruction through fetch, decode and execute states using the IR opcode, and inserts wait cycles on data-memory accesses.
- Provides a trap state for illegal opcodes, plus cycle and instruction counters for debug.

Parameters:
- CNT_WIDTH, 32: width of cycle_cnt and instr_cnt.
- TRAP_EN, 1: 1 = an illegal opcode enters TRAP; 0 = an illegal opcode returns to FETCH (executes as a NOP).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26]; valid from DECODE until the instruction completes.
- dmem_ready  input  1  data memory done; sampled only in MEMRD and MEMWR.
- current_state  output  4  state code driven to the control decoder.
- instr_done  output  1  registered one-cycle pulse after each completed instruction.
- trap  output  1  high while in TRAP.
- cycle_cnt  output  CNT_WIDTH  cycles since reset.
- instr_cnt  output  CNT_WIDTH  completed instructions since reset.

Behaviour:
- State codes:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB, 8 BRANCH, 9 JUMP, 10 TRAP.
  - Codes 11-15 are unused.
- Reset (async, immediate, valid mid-instruction): current_state=0, instr_done=0, trap=0, cycle_cnt=0, instr_cnt=0.
- Transitions (one per rising edge unless stalled):
  - FETCH -> DECODE, always. No stall in FETCH: PCWrite/IRWrite must assert for exactly one cycle.
  - DECODE by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXEC.
    - 000100 (beq) -> BRANCH.
    - 000010 (j) -> JUMP.
    - Any other opcode -> TRAP if TRAP_EN=1, else FETCH.
  - MEMADR: 100011 -> MEMRD; 101011 -> MEMWR. Opcode is re-sampled here; if it is neither, go to TRAP (TRAP_EN=1) or FETCH.
  - MEMRD: stay while dmem_ready=0; -> MEMWB when dmem_ready=1.
  - MEMWR: stay while dmem_ready=0; -> FETCH when dmem_ready=1.
  - MEMWB, RWB, BRANCH, JUMP -> FETCH.
  - EXEC -> RWB.
  - TRAP: held until rst.
  - Unused codes 11-15 (unreachable) -> FETCH.
- Latency with no stalls, FETCH to next FETCH: lw 5, sw 4, R 4, beq 3, j 3 cycles. Each stalled cycle adds 1.
- Completion event: any transition into FETCH from MEMWB, MEMWR, RWB, BRANCH or JUMP.
  - On that edge, instr_done is registered to 1 (high during the first FETCH cycle of the next instruction) and instr_cnt increments by 1.
  - Otherwise instr_done=0.
  - The TRAP_EN=0 illegal path (DECODE/MEMADR -> FETCH) is not a completion: no pulse, no count.
- cycle_cnt:
  - Increments every cycle, including stall and TRAP cycles; wraps modulo 2^CNT_WIDTH.
  - Saturation is not required.
- instr_cnt wraps modulo 2^CNT_WIDTH.
- trap is registered and equals (current_state==10). Entry into TRAP produces no instr_done.
- dmem_ready is ignored in all states other than 3 and 5.

Test Plan:
- Reset mid-MEMRD: assert rst asynchronously -> current_state=0 and counters=0 before the next edge; release -> state sequence 0,1 on successive edges.
- lw (100011), dmem_ready=1 -> states 0,1,2,3,4,0. instr_done high exactly in the cycle after 4. instr_cnt 0->1. cycle_cnt=5 at the second FETCH.
- sw (101011) with dmem_ready low 3 cycles in MEMWR -> states 0,1,2,5,5,5,5,0. Total 7 cycles. One instr_done pulse.
- Back-to-back R-type, beq, j -> sequences 0,1,6,7 / 0,1,8 / 0,1,9 / 0. instr_cnt=3 after 10 cycles. instr_done pulses at cycles 4, 7 and 10 (the FETCH cycle after each completion).
- Illegal opcode 111111 with TRAP_EN=1 -> 0,1,10, then held at 10 for 20 cycles. trap=1, cycle_cnt still increments, instr_cnt unchanged. With TRAP_EN=0 -> 0,1,0, no instr_done.
- Counter wrap with CNT_WIDTH=4: run 16 cycles -> cycle_cnt returns to 0. Run 16 j instructions -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/multi_cycle_sequencer.sv
// State register and next-state logic for the multi-cycle MIPS datapath.
// Also produces the instruction-complete pulse, trap flag and debug counters.
module multi_cycle_sequencer #(
  parameter int CNT_WIDTH = 32,
  parameter bit TRAP_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 dmem_ready,
  output logic [3:0]           current_state,
  output logic                 instr_done,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Where an illegal opcode sends the machine.
  localparam state_t ILLEGAL_NEXT = TRAP_EN ? S_TRAP : S_FETCH;

  state_t               state_q, state_d;
  logic                 instr_done_q, instr_done_d;
  logic                 trap_q, trap_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      instr_done_q <= 1'b0;
      trap_q       <= 1'b0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
      trap_q       <= trap_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_done_d = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMRD: begin
        if (dmem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        if (dmem_ready) begin
          state_d      = S_FETCH;
          instr_done_d = 1'b1;
        end
      end
      S_EXEC: state_d = S_RWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: begin
        state_d      = S_FETCH;
        instr_done_d = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    trap_d      = (state_d == S_TRAP);
    cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    instr_cnt_d = instr_done_d ? (instr_cnt_q + CNT_ONE) : instr_cnt_q;
  end

  assign current_state = state_q;
  assign instr_done    = instr_done_q;
  assign trap          = trap_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign instr_cnt     = instr_cnt_q;

endmodule
